// File: rtl/gb_cpu_sequencer.sv
// Game Boy CPU M-cycle/T-cycle sequencer: owns IR + CB prefix, walks the decoded schedule, hard-locks on illegal opcodes.
// Latency: an opcode on mem_rdata is in the IR one clock after the t_cycle==3 edge of a fetch M-cycle (4 clocks per M-cycle).
// Backpressure: stall freezes every counter and all state; a boundary held by stall defers the IR load and instr_done.
module gb_cpu_sequencer #(
    parameter int MAX_M_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic [7:0] mem_rdata,
    input  logic [2:0] sched_len,
    input  logic [2:0] sched_cond_m,
    input  logic       cond_true,
    output logic [7:0] ir_opcode,
    output logic       ir_cb_prefix,
    output logic [2:0] m_cycle,
    output logic [1:0] t_cycle,
    output logic       fetch_m,
    output logic       instr_done,
    output logic       locked
);

    typedef enum logic [1:0] {
        ST_EXEC     = 2'd0,
        ST_CB_FETCH = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [2:0] MAX_M = 3'(MAX_M_CYCLES);

    state_t     state_q;
    logic [7:0] ir_q;
    logic       cb_q;
    logic [2:0] m_q;
    logic [1:0] t_q;

    logic [2:0] len_eff;
    logic       last_m;
    logic       boundary;
    logic [1:0] t_d;

    // Opcodes that freeze the real CPU until reset.
    function automatic logic is_hard_lock(input logic [7:0] op);
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_hard_lock = 1'b1;
            default:                           is_hard_lock = 1'b0;
        endcase
    endfunction

    // Effective schedule length, last-M-cycle detection and the M-cycle boundary strobe.
    always_comb begin
        if (sched_len == 3'd0) begin
            len_eff = 3'd1;
        end else if (sched_len > MAX_M) begin
            len_eff = MAX_M;
        end else begin
            len_eff = sched_len;
        end
        // ">=" rather than "==" so a schedule that shrinks under us ends the instruction here
        // instead of letting m_cycle run past the schedule.
        last_m   = (m_q >= (len_eff - 3'd1)) | ((m_q == sched_cond_m) & ~cond_true);
        boundary = (t_q == 2'd3) & ~stall;
        t_d      = t_q + 2'd1;
    end

    // Sequencer FSM: counters, instruction register and prefix flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXEC;
            ir_q    <= 8'h00;
            cb_q    <= 1'b0;
            m_q     <= 3'd0;
            t_q     <= 2'd0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (!stall) begin
                        t_q <= t_d;
                    end
                    if (boundary) begin
                        if (last_m) begin
                            m_q  <= 3'd0;
                            ir_q <= mem_rdata;
                            cb_q <= 1'b0;
                            if (mem_rdata == 8'hCB) begin
                                state_q <= ST_CB_FETCH;
                            end else if (is_hard_lock(mem_rdata)) begin
                                state_q <= ST_LOCKED;
                            end
                        end else begin
                            m_q <= m_q + 3'd1;
                        end
                    end
                end
                ST_CB_FETCH: begin
                    // Second opcode byte: never another prefix, never a lock opcode.
                    if (!stall) begin
                        t_q <= t_d;
                    end
                    if (boundary) begin
                        ir_q    <= mem_rdata;
                        cb_q    <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_LOCKED: begin
                    m_q <= 3'd0;
                    t_q <= 2'd0;
                end
                default: begin
                    state_q <= ST_EXEC;
                    m_q     <= 3'd0;
                    t_q     <= 2'd0;
                end
            endcase
        end
    end

    // Output mapping; fetch_m and instr_done follow the live schedule inputs.
    always_comb begin
        ir_opcode    = ir_q;
        ir_cb_prefix = cb_q;
        m_cycle      = m_q;
        t_cycle      = t_q;
        locked       = (state_q == ST_LOCKED);
        fetch_m      = 1'b0;
        instr_done   = 1'b0;
        case (state_q)
            ST_EXEC: begin
                fetch_m    = last_m;
                instr_done = boundary & last_m;
            end
            ST_CB_FETCH: fetch_m = 1'b1;
            default: begin
                fetch_m    = 1'b0;
                instr_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed bench for gb_cpu_sequencer with a cycle-level reference model and literal spot checks.
// Inputs change 2 time units after a rising edge; the model advances on the rising edge.
// Outputs are compared against the model on every falling edge.
module tb_gb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [2:0] sched_len = 3'd1;
    logic [2:0] sched_cond_m = 3'd7;
    logic       cond_true = 1'b0;
    logic [7:0] ir_opcode;
    logic       ir_cb_prefix;
    logic [2:0] m_cycle;
    logic [1:0] t_cycle;
    logic       fetch_m;
    logic       instr_done;
    logic       locked;

    int checks = 0;
    int errors = 0;

    gb_cpu_sequencer #(.MAX_M_CYCLES(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .mem_rdata    (mem_rdata),
        .sched_len    (sched_len),
        .sched_cond_m (sched_cond_m),
        .cond_true    (cond_true),
        .ir_opcode    (ir_opcode),
        .ir_cb_prefix (ir_cb_prefix),
        .m_cycle      (m_cycle),
        .t_cycle      (t_cycle),
        .fetch_m      (fetch_m),
        .instr_done   (instr_done),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position in the instruction is kept as elapsed T-cycles; mode 0=normal, 1=prefix fetch, 2=locked.
    int         mdl_tick = 0;
    int         mdl_mode = 0;
    logic [7:0] mdl_ir = 8'h00;
    logic       mdl_cb = 1'b0;
    int         mdl_dones = 0;
    int         dut_dones = 0;

    byte unsigned lock_ops [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                    8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

    function automatic bit in_lock_list(input logic [7:0] op);
        for (int i = 0; i < 11; i++) begin
            if (op == lock_ops[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int schedule_len(input logic [2:0] sl);
        if (sl == 3'd0) return 1;
        if (int'(sl) > 6) return 6;
        return int'(sl);
    endfunction

    function automatic bit model_last(input int tick, input logic [2:0] sl,
                                      input logic [2:0] cm, input logic ct);
        int m;
        m = tick / 4;
        return (m + 1 >= schedule_len(sl)) || (m == int'(cm) && !ct);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_tick = 0;
            mdl_mode = 0;
            mdl_ir   = 8'h00;
            mdl_cb   = 1'b0;
        end else if (mdl_mode != 2 && !stall) begin
            if (mdl_tick % 4 != 3) begin
                mdl_tick++;
            end else if (mdl_mode == 1) begin
                mdl_ir   = mem_rdata;
                mdl_cb   = 1'b1;
                mdl_mode = 0;
                mdl_tick = 0;
            end else if (model_last(mdl_tick, sched_len, sched_cond_m, cond_true)) begin
                mdl_dones++;
                mdl_ir   = mem_rdata;
                mdl_cb   = 1'b0;
                mdl_tick = 0;
                mdl_mode = (mem_rdata == 8'hCB) ? 1 : (in_lock_list(mem_rdata) ? 2 : 0);
            end else begin
                mdl_tick++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit lst;
        lst = model_last(mdl_tick, sched_len, sched_cond_m, cond_true);
        if (instr_done === 1'b1) dut_dones++;
        check("ir_opcode",    int'(ir_opcode),    int'(mdl_ir));
        check("ir_cb_prefix", int'(ir_cb_prefix), int'(mdl_cb));
        check("m_cycle",      int'(m_cycle),      mdl_tick / 4);
        check("t_cycle",      int'(t_cycle),      mdl_tick % 4);
        check("locked",       int'(locked),       (mdl_mode == 2) ? 1 : 0);
        check("fetch_m",      int'(fetch_m),
              (mdl_mode == 1) ? 1 : ((mdl_mode == 0) ? int'(lst) : 0));
        check("instr_done",   int'(instr_done),
              (mdl_mode == 0 && mdl_tick % 4 == 3 && !stall && lst) ? 1 : 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        // Reset values
        step(2);
        check("rst_ir",     int'(ir_opcode),  8'h00);
        check("rst_m",      int'(m_cycle),    0);
        check("rst_t",      int'(t_cycle),    0);
        check("rst_locked", int'(locked),     0);
        check("rst_done",   int'(instr_done), 0);
        rst_n = 1'b1;
        mem_rdata = 8'h3C;
        sched_len = 3'd1;

        // INC A: one M-cycle, done at clock 3, IR loaded at clock 4
        step(3);
        check("inc_t3",    int'(t_cycle),    3);
        check("inc_done",  int'(instr_done), 1);
        step(1);
        check("inc_ir",    int'(ir_opcode),  8'h3C);
        check("inc_t0",    int'(t_cycle),    0);
        mem_rdata = 8'h80;

        // Two M-cycle instruction: fetch only in m1, reload after 8 clocks
        step(4);
        check("add_ir",    int'(ir_opcode),  8'h80);
        sched_len = 3'd2;
        mem_rdata = 8'h00;
        step(3);
        check("add_m0",    int'(m_cycle),    0);
        check("add_f0",    int'(fetch_m),    0);
        check("add_d0",    int'(instr_done), 0);
        step(1);
        check("add_m1",    int'(m_cycle),    1);
        check("add_f1",    int'(fetch_m),    1);
        step(3);
        check("add_done",  int'(instr_done), 1);
        step(1);
        check("add_ir2",   int'(ir_opcode),  8'h00);
        check("add_mwrap", int'(m_cycle),    0);

        // CB prefix then 37
        sched_len = 3'd1;
        mem_rdata = 8'hCB;
        step(4);
        check("cb_ir",     int'(ir_opcode),    8'hCB);
        check("cb_pfx0",   int'(ir_cb_prefix), 0);
        check("cb_fetch",  int'(fetch_m),      1);
        mem_rdata = 8'h37;
        step(3);
        check("cb_nodone", int'(instr_done),   0);
        check("cb_m",      int'(m_cycle),      0);
        step(1);
        check("cb_ir2",    int'(ir_opcode),    8'h37);
        check("cb_pfx1",   int'(ir_cb_prefix), 1);
        mem_rdata = 8'h00;

        // Conditional truncation at m1
        sched_len = 3'd3;
        sched_cond_m = 3'd1;
        cond_true = 1'b0;
        step(7);
        check("cf_m1",     int'(m_cycle),    1);
        check("cf_done",   int'(instr_done), 1);
        step(1);
        check("cf_mwrap",  int'(m_cycle),    0);
        cond_true = 1'b1;
        step(7);
        check("ct_nodone", int'(instr_done), 0);
        step(1);
        check("ct_m2",     int'(m_cycle),    2);
        step(3);
        check("ct_done",   int'(instr_done), 1);
        step(1);
        sched_cond_m = 3'd0;
        cond_true = 1'b0;
        step(3);
        check("c0_done",   int'(instr_done), 1);
        step(1);
        sched_cond_m = 3'd7;

        // Length clamp, zero length, schedule shrinking mid-instruction
        sched_len = 3'd7;
        step(23);
        check("clamp_m5",  int'(m_cycle),    5);
        check("clamp_dn",  int'(instr_done), 1);
        step(1);
        sched_len = 3'd0;
        step(3);
        check("zero_done", int'(instr_done), 1);
        step(1);
        sched_len = 3'd4;
        step(8);
        check("shr_m2",    int'(m_cycle),    2);
        sched_len = 3'd1;
        step(3);
        check("shr_done",  int'(instr_done), 1);
        check("shr_m",     int'(m_cycle),    2);
        step(1);
        check("shr_mwrap", int'(m_cycle),    0);

        // Stall on the boundary
        mem_rdata = 8'h3C;
        step(3);
        check("st_pre",    int'(instr_done), 1);
        stall = 1'b1;
        step(5);
        check("st_t3",     int'(t_cycle),    3);
        check("st_nodone", int'(instr_done), 0);
        check("st_ir",     int'(ir_opcode),  8'h00);
        stall = 1'b0;
        #1;
        check("st_rel",    int'(instr_done), 1);
        step(1);
        check("st_ir2",    int'(ir_opcode),  8'h3C);
        check("st_t0",     int'(t_cycle),    0);

        // CB CB is an ordinary CB opcode
        mem_rdata = 8'hCB;
        step(4);
        step(4);
        check("cbcb_ir",   int'(ir_opcode),    8'hCB);
        check("cbcb_pfx",  int'(ir_cb_prefix), 1);
        mem_rdata = 8'h00;
        step(4);
        check("cbcb_nx",   int'(ir_opcode),    8'h00);
        check("cbcb_np",   int'(ir_cb_prefix), 0);

        // Hard lock and recovery by reset
        mem_rdata = 8'hD3;
        step(4);
        check("lk_on",     int'(locked),     1);
        check("lk_ir",     int'(ir_opcode),  8'hD3);
        mem_rdata = 8'h00;
        step(20);
        check("lk_hold",   int'(locked),     1);
        check("lk_t",      int'(t_cycle),    0);
        check("lk_m",      int'(m_cycle),    0);
        check("lk_fetch",  int'(fetch_m),    0);
        check("lk_ir2",    int'(ir_opcode),  8'hD3);
        rst_n = 1'b0;
        #1;
        check("lk_rst_ir", int'(ir_opcode),  8'h00);
        check("lk_rst_lk", int'(locked),     0);
        step(1);
        rst_n = 1'b1;
        mem_rdata = 8'h3C;
        step(3);
        check("rr_done",   int'(instr_done), 1);
        step(1);
        check("rr_ir",     int'(ir_opcode),  8'h3C);

        @(negedge clk);
        #1;
        check("done_count", dut_dones, mdl_dones);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
